// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder: USB receive line decoder.
// Synchronizes D+/D-, recovers bit timing from line transitions, NRZI-decodes
// each bit, detects end-of-packet and flags illegal line activity.
// Optional feature: define USB_RX_UNSTUFF_EN to enable stuffed-bit removal
// (a ones counter that drops the bit after six consecutive 1s and flags a
// stuff error when that bit is a 1). Without it every decoded bit is emitted.
module usb_rx_decoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_plus,
    input  logic d_minus,
    output logic rx_bit,
    output logic rx_valid,
    output logic rx_active,
    output logic eop,
    output logic rx_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    // Line states as {D+, D-}
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_SE1 = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_SE0, S_ERROR} state_t;

    state_t           state, state_nxt;
    logic             dp_p0, dp_p1, dp_p2;
    logic             dm_p0, dm_p1, dm_p2;
    logic [1:0]       line_p1, line_p2, samp;
    logic             line_edge, strobe, dec_bit;
    logic [CNT_W-1:0] cnt;
    logic             last_dp, last_dp_nxt;
    logic [1:0]       se0_cnt, se0_cnt_nxt;
    logic             err_se0, err_se0_nxt;
    logic             vld_nxt, bit_nxt, eop_nxt, err_nxt;
`ifdef USB_RX_UNSTUFF_EN
    logic [2:0]       ones, ones_nxt;
`endif

    // Two-flop synchronizer plus one delayed copy for edge detection; all idle at J
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_p0 <= 1'b1; dp_p1 <= 1'b1; dp_p2 <= 1'b1;
            dm_p0 <= 1'b0; dm_p1 <= 1'b0; dm_p2 <= 1'b0;
        end else begin
            dp_p0 <= d_plus;  dp_p1 <= dp_p0; dp_p2 <= dp_p1;
            dm_p0 <= d_minus; dm_p1 <= dm_p0; dm_p2 <= dm_p1;
        end
    end

    assign line_p1   = {dp_p1, dm_p1};
    assign line_p2   = {dp_p2, dm_p2};
    assign line_edge = (line_p1 != line_p2);
    // The delayed copy is the pre-edge value, so sampling it is correct even
    // when an edge and the sample point coincide.
    assign samp      = line_p2;
    assign strobe    = (state != S_IDLE) && (cnt == HALF);
    assign dec_bit   = (samp[1] == last_dp);

    // Bit timer: resynchronized by every line edge, parked at 0 while idle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)                          cnt <= '0;
        else if (state == S_IDLE || line_edge) cnt <= '0;
        else if (cnt == LAST)                cnt <= '0;
        else                                 cnt <= cnt + CNT_W'(1);
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (line_edge && line_p1 == LS_K) state_nxt = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (strobe) begin
                    if (samp == LS_SE0)      state_nxt = S_SE0;
                    else if (samp == LS_SE1) state_nxt = S_ERROR;
`ifdef USB_RX_UNSTUFF_EN
                    else if (ones == 3'd6 && dec_bit) state_nxt = S_ERROR;
`endif
                end
            end
            S_SE0: begin
                if (strobe) begin
                    if (samp == LS_SE0)                      state_nxt = S_SE0;
                    else if (samp == LS_J && se0_cnt >= 2'd2) state_nxt = S_IDLE;
                    else                                     state_nxt = S_ERROR;
                end
            end
            S_ERROR: begin
                if (strobe && samp == LS_J && err_se0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and datapath next values; rx_active decodes the current state
    always_comb begin
        rx_active   = (state == S_ACTIVE) || (state == S_SE0);
        vld_nxt     = 1'b0;
        bit_nxt     = dec_bit;
        eop_nxt     = 1'b0;
        err_nxt     = 1'b0;
        last_dp_nxt = last_dp;
        se0_cnt_nxt = se0_cnt;
        err_se0_nxt = 1'b0;
`ifdef USB_RX_UNSTUFF_EN
        ones_nxt    = ones;
`endif
        case (state)
            S_ACTIVE: begin
                if (strobe) begin
                    if (samp == LS_SE0) begin
                        se0_cnt_nxt = 2'd1;
                    end else if (samp == LS_SE1) begin
                        err_nxt = 1'b1;
                    end else begin
                        last_dp_nxt = samp[1];
`ifdef USB_RX_UNSTUFF_EN
                        if (ones == 3'd6) begin
                            // Stuffed bit: consumed, must be a 0
                            if (dec_bit) err_nxt  = 1'b1;
                            else         ones_nxt = 3'd0;
                        end else begin
                            vld_nxt  = 1'b1;
                            ones_nxt = dec_bit ? ones + 3'd1 : 3'd0;
                        end
`else
                        vld_nxt = 1'b1;
`endif
                    end
                end
            end
            S_SE0: begin
                if (strobe) begin
                    if (samp == LS_SE0) begin
                        if (se0_cnt != 2'd3) se0_cnt_nxt = se0_cnt + 2'd1;
                    end else if (samp == LS_J && se0_cnt >= 2'd2) begin
                        eop_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_ERROR: begin
                // Remember whether the latest sample was SE0; J right after it ends recovery
                err_se0_nxt = strobe ? (samp == LS_SE0) : err_se0;
            end
            default: ;
        endcase
        if (state_nxt == S_IDLE) begin
            last_dp_nxt = 1'b1;
`ifdef USB_RX_UNSTUFF_EN
            ones_nxt    = 3'd0;
`endif
        end
    end

    // Registered outputs and decoder context
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_valid <= 1'b0;
            rx_bit   <= 1'b0;
            eop      <= 1'b0;
            rx_error <= 1'b0;
            last_dp  <= 1'b1;
            se0_cnt  <= 2'd0;
            err_se0  <= 1'b0;
`ifdef USB_RX_UNSTUFF_EN
            ones     <= 3'd0;
`endif
        end else begin
            rx_valid <= vld_nxt;
            rx_bit   <= vld_nxt & bit_nxt;
            eop      <= eop_nxt;
            rx_error <= err_nxt;
            last_dp  <= last_dp_nxt;
            se0_cnt  <= se0_cnt_nxt;
            err_se0  <= err_se0_nxt;
`ifdef USB_RX_UNSTUFF_EN
            ones     <= ones_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// tb_usb_rx_decoder: directed bench for usb_rx_decoder at 8 clocks per bit.
// Line sequences are strings of bit-time symbols: J, K, 0 (SE0), 1 (SE1).
module tb_usb_rx_decoder;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic d_plus = 1'b1;
    logic d_minus = 1'b0;
    logic rx_bit, rx_valid, rx_active, eop, rx_error;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   drive_cyc = 0;
    int   t_start = 0;
    int   first_cyc = -1;
    int   eop_n = 0;
    int   err_n = 0;
    logic act_at_pulse = 1'b1;
    logic bits_q[$];

    usb_rx_decoder #(.CLKS_PER_BIT(8)) dut (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .d_minus(d_minus),
        .rx_bit(rx_bit), .rx_valid(rx_valid), .rx_active(rx_active),
        .eop(eop), .rx_error(rx_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes and pulses shortly after each active edge
    always @(posedge clk) begin
        #1;
        if (n_rst) begin
            if (rx_valid) begin
                bits_q.push_back(rx_bit);
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (eop) eop_n++;
            if (rx_error) err_n++;
            if (eop || rx_error) act_at_pulse = rx_active;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_bits();
        logic [31:0] v = '0;
        foreach (bits_q[i]) v = {v[30:0], bits_q[i]};
        return v;
    endfunction

    task automatic clear_log();
        bits_q.delete();
        eop_n = 0;
        err_n = 0;
        first_cyc = -1;
        act_at_pulse = 1'b1;
    endtask

    task automatic line(input logic [1:0] st, input int n);
        @(negedge clk);
        d_plus  = st[1];
        d_minus = st[0];
        drive_cyc = cyc;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic play(input string s, input int long_i, input int short_i);
        logic [1:0] st;
        int n;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "J")      st = 2'b10;
            else if (s[i] == "K") st = 2'b01;
            else if (s[i] == "0") st = 2'b00;
            else                  st = 2'b11;
            n = (i == long_i) ? 9 : (i == short_i) ? 7 : 8;
            line(st, n);
            if (i == 0) t_start = drive_cyc;
        end
    endtask

    task automatic check_pkt(input string tag, input int len, input logic [31:0] val,
                             input int n_eop, input int n_err);
        check({tag, "_len"}, bits_q.size(), len);
        check({tag, "_bits"}, pack_bits(), val);
        check({tag, "_eop"}, eop_n, n_eop);
        check({tag, "_err"}, err_n, n_err);
    endtask

    initial begin
        // Reset with the lines at J
        repeat (3) @(negedge clk);
        check("rst_outs", {27'd0, rx_bit, rx_valid, rx_active, eop, rx_error}, 32'd0);
        n_rst = 1'b1;
        clear_log();
        repeat (20) @(negedge clk);
        check("idle_strobes", bits_q.size(), 0);
        check("idle_pulses", eop_n + err_n, 0);

        // Sync field, then a two-bit SE0 and J
        clear_log();
        play("KJKJKJKK", -1, -1);
        check("sync_active", rx_active, 1'b1);
        check("sync_latency", first_cyc - t_start, 8);
        play("00JJ", -1, -1);
        check_pkt("sync", 8, 32'h01, 1, 0);
        check("sync_act_at_eop", act_at_pulse, 1'b0);
        check("sync_act_after", rx_active, 1'b0);

        // Single SE0 bit then J is malformed; then recover through SE0, J
        clear_log();
        play("KJKJKJKK0J0JJ", -1, -1);
        check_pkt("se0short", 8, 32'h01, 0, 1);
        check("se0short_act_at_err", act_at_pulse, 1'b0);

        // 0x7E after sync: six 1s, stuffed 0, then a 0
        clear_log();
        play("KJKJKJKKJJJJJJJKJ00JJ", -1, -1);
`ifdef USB_RX_UNSTUFF_EN
        check_pkt("stuff", 16, 32'b00000001_01111110, 1, 0);
`else
        check_pkt("stuff", 17, 32'b00000001_011111100, 1, 0);
`endif

        // Seven unchanged line states after a 0
        clear_log();
        play("KJKJKJKKJJJJJJJJK00JJ", -1, -1);
`ifdef USB_RX_UNSTUFF_EN
        check_pkt("seven", 15, 32'b00000001_0111111, 0, 1);
        check("seven_act_at_err", act_at_pulse, 1'b0);
`else
        check_pkt("seven", 17, 32'b00000001_011111110, 1, 0);
`endif

        // Jitter: bit 2 stretched to 9 clocks, bit 5 shortened to 7
        clear_log();
        play("KJKJKJKK00JJ", 2, 5);
        check_pkt("jitter", 8, 32'h01, 1, 0);

        // Reset during the 4th bit, then a fresh packet
        clear_log();
        line(2'b01, 8);
        line(2'b10, 8);
        line(2'b01, 8);
        line(2'b10, 4);
        check("pre_rst_active", rx_active, 1'b1);
        n_rst = 1'b0;
        #1;
        check("midrst_outs", {27'd0, rx_bit, rx_valid, rx_active, eop, rx_error}, 32'd0);
        line(2'b10, 3);
        n_rst = 1'b1;
        line(2'b10, 20);
        clear_log();
        play("KJKJKJKK00JJ", -1, -1);
        check_pkt("after_rst", 8, 32'h01, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_decoder.md
# usb_rx_decoder

Receive-side line decoder for the USB transceiver: the receive counterpart of the transmit NRZI encoder. It synchronizes the raw `d_plus`/`d_minus` pair, recovers bit timing from line transitions, and NRZI-decodes each bit. It also removes stuffed bits and detects end-of-packet. It feeds a one-bit-per-strobe stream to the receive shift register and the receive control FSM.

## Interface
- `CLKS_PER_BIT`, default 8: system clocks per USB bit; even, ≥4.
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous active-low reset.
- `d_plus` in 1: raw D+ line, asynchronous to `clk`.
- `d_minus` in 1: raw D− line, asynchronous to `clk`.
- `rx_bit` out 1: decoded data bit; valid only while `rx_valid` = 1.
- `rx_valid` out 1: one-cycle strobe, new decoded bit on `rx_bit`.
- `rx_active` out 1: level; high from first K until EOP or error.
- `eop` out 1: one-cycle pulse on a valid end-of-packet.
- `rx_error` out 1: one-cycle pulse on a stuff error or illegal line state.

## Operation
- **Synchronizer:** two flops per line; reset values D+ = 1, D− = 0 (J).
- **Line states:** J = {1,0}, K = {0,1}, SE0 = {0,0}, SE1 = {1,1}.
- **Edge detect:** `edge` = synchronized pair ≠ its one-cycle-delayed copy. The delayed copy also resets to J.
- **Bit timer:** counter of width clog2(CLKS_PER_BIT).
  - On `edge`, the counter loads 0; otherwise it increments, wrapping CLKS_PER_BIT−1 → 0.
  - Held at 0 in IDLE.
  - Sample strobe when the counter equals CLKS_PER_BIT/2.
- **Reference register:** `last_dp` holds the previously sampled D+. It is set to 1 (J) on reset and on every entry to IDLE.
- **State machine:** IDLE, ACTIVE, SE0, ERROR; reset state IDLE.
  - **IDLE:** on `edge` to K, go to ACTIVE and clear the timer.
  - **ACTIVE, sample of J or K:**
    - Decoded bit = 1 if sampled D+ equals `last_dp`, else 0.
    - Update `last_dp`.
    - Emit the bit, subject to unstuffing.
  - **ACTIVE, sample of SE0:** go to SE0 with se0_cnt = 1.
  - **ACTIVE, sample of SE1:** pulse `rx_error`, go to ERROR.
  - **SE0, at each sample:**
    - SE0: increment se0_cnt, saturating at 3.
    - J with se0_cnt ≥ 2: pulse `eop`, go to IDLE.
    - Any other case: pulse `rx_error`, go to ERROR.
  - **ERROR:** output strobes suppressed. Wait for a sample of SE0 followed by a sample of J, then go to IDLE with no `eop` pulse.
- **Unstuffing:**
  - A 3-bit ones counter increments on each decoded 1 and clears on each decoded 0.
  - When the count is 6, the next decoded bit is consumed without `rx_valid`.
    - If that bit is 0: the counter clears.
    - If that bit is 1: pulse `rx_error`, go to ERROR.
  - The ones counter clears in IDLE.
- **`rx_active`:** high in ACTIVE and SE0; low in IDLE and ERROR.
- **Reset mid-packet:** all state returns immediately to IDLE; all outputs go to 0.

## Timing
- **Reset values:** `rx_bit`, `rx_valid`, `rx_active`, `eop`, `rx_error` all 0.
- **Input latency:** a line change becomes visible to edge detect 2 clocks after it is captured (synchronizer).
- **Bit output:** with `edge` in cycle E, the counter is 0 in E+1 and reaches CLKS_PER_BIT/2 in E+1+CLKS_PER_BIT/2. `rx_valid`/`rx_bit` are registered and asserted in E+2+CLKS_PER_BIT/2.
- **Strobe rate:** at most one `rx_valid` per bit period.
- **Pulse widths:** `eop` and `rx_error` are registered, one cycle, and coincide with the strobe timing of the sample that caused them.
- **`rx_active` transitions:**
  - Rises 1 cycle after the IDLE→ACTIVE edge.
  - Falls in the same cycle as the `eop`/`rx_error` pulse.
- **Jitter tolerance:** because every edge resynchronizes the timer, a bit period of CLKS_PER_BIT±1 clocks is tolerated.
- **Simultaneous events:** `edge` and sample strobe in the same cycle → the sample uses the pre-edge synchronized value, and the timer loads 0.

## Configuration
- **Macro:** `USB_RX_UNSTUFF_EN`.
- **Defined:** ones counter and stuffed-bit removal as specified; a stuff error pulses `rx_error`.
- **Undefined:** no ones counter; every decoded bit in ACTIVE produces `rx_valid`; `rx_error` arises only from SE1 or a malformed SE0 sequence.

## Test plan
- **Reset:** assert `n_rst` with the lines at J → all outputs 0, state IDLE; hold 20 clocks → no strobes.
- **Sync field:** drive KJKJKJKK at 8 clocks/bit → 8 `rx_valid` pulses with bits 0,0,0,0,0,0,0,1; `rx_active` = 1.
- **Unstuffing:**
  - Data 0x7E (six 1s) followed by a stuffed 0 → six 1-bits emitted, stuffed bit dropped, next bit decodes correctly.
  - Seven unchanged line states → `rx_error` pulse, `rx_active` = 0.
  - With `USB_RX_UNSTUFF_EN` undefined, seven unchanged line states → seven 1-bits emitted, no error.
- **EOP:** after data, 2 bits of SE0 then J → one `eop` pulse, `rx_active` falls, state IDLE. A single SE0 bit then J → `rx_error`.
- **Jitter:** sync field with one bit stretched to 9 clocks and one shortened to 7 → identical decoded bits, no error.
- **Reset mid-packet:** pulse `n_rst` low during the 4th bit → outputs 0 immediately. A following fresh sync field decodes correctly from its first K.
